// File: rtl/trivium_stream_decrypt.sv
// Trivium stream decryptor: XORs ciphertext words with WORD_BITS keystream bits per clock.
// A start pulse loads key/IV and runs a 1152-step warm-up before data is accepted.
module trivium_stream_decrypt #(
  parameter int WORD_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [79:0]          key,
  input  logic [79:0]          iv,
  output logic                 busy,
  output logic                 ks_ready,
  input  logic                 ct_valid,
  output logic                 ct_ready,
  input  logic [WORD_BITS-1:0] ct_data,
  output logic                 pt_valid,
  input  logic                 pt_ready,
  output logic [WORD_BITS-1:0] pt_data
);

  localparam int WARMUP_CYCLES = 1152 / WORD_BITS;
  localparam int CNT_W = $clog2(WARMUP_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_WARMUP = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    RUN
  } fsm_t;

  fsm_t                 fsm_q;
  fsm_t                 fsm_d;
  logic [287:0]         state_q;
  logic [287:0]         state_adv;
  logic [287:0]         state_load;
  logic [CNT_W-1:0]     counter_q;
  logic [WORD_BITS-1:0] ks_word;
  logic                 ct_accept;
  logic                 pt_drain;

  // Bit s_i of the Trivium register lives at index i-1; result is {z, next_state}.
  function automatic logic [288:0] trivium_step(input logic [287:0] s);
    logic         t1;
    logic         t2;
    logic         t3;
    logic         z;
    logic [287:0] n;
    t1 = s[65] ^ s[92];
    t2 = s[161] ^ s[176];
    t3 = s[242] ^ s[287];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[90] & s[91]) ^ s[170];
    t2 = t2 ^ (s[174] & s[175]) ^ s[263];
    t3 = t3 ^ (s[285] & s[286]) ^ s[68];
    n[92:0]    = {s[91:0], t3};
    n[176:93]  = {s[175:93], t1};
    n[287:177] = {s[286:177], t2};
    return {z, n};
  endfunction

  always_comb begin
    logic [287:0] s;
    logic [288:0] r;
    s       = state_q;
    r       = '0;
    ks_word = '0;
    for (int i = 0; i < WORD_BITS; i++) begin
      r          = trivium_step(s);
      ks_word[i] = r[288];
      s          = r[287:0];
    end
    state_adv = s;
  end

  always_comb begin
    state_load          = '0;
    state_load[79:0]    = key;
    state_load[172:93]  = iv;
    state_load[287:285] = 3'b111;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    if (start) begin
      fsm_d = WARMUP;
    end else begin
      case (fsm_q)
        WARMUP:  if (counter_q == LAST_WARMUP) fsm_d = RUN;
        RUN:     fsm_d = RUN;
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (fsm_q == WARMUP);
    ks_ready = (fsm_q == RUN);
    ct_ready = (fsm_q == RUN) && (!pt_valid || pt_ready);
  end

  assign ct_accept = ct_valid & ct_ready;
  assign pt_drain  = pt_valid & pt_ready;

  // Keystream only advances on warm-up cycles or accepted ciphertext words.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= '0;
      counter_q <= '0;
      pt_valid  <= 1'b0;
      pt_data   <= '0;
    end else if (start) begin
      state_q   <= state_load;
      counter_q <= '0;
      pt_valid  <= 1'b0;
    end else if (fsm_q == WARMUP) begin
      state_q   <= state_adv;
      counter_q <= counter_q + CNT_ONE;
    end else if (fsm_q == RUN) begin
      if (ct_accept) begin
        state_q  <= state_adv;
        pt_data  <= ct_data ^ ks_word;
        pt_valid <= 1'b1;
      end else if (pt_drain) begin
        pt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trivium_stream_decrypt.sv
// Directed bench for trivium_stream_decrypt at WORD_BITS 8, 1 and 64,
// checked against a bit-serial Trivium reference model.
module tb_trivium_stream_decrypt;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] key;
  logic [79:0] iv;

  logic        start8, busy8, ks_ready8, ct_valid8, ct_ready8, pt_valid8, pt_ready8;
  logic [7:0]  ct_data8, pt_data8;
  logic        start1, busy1, ks_ready1, ct_valid1, ct_ready1, pt_valid1, pt_ready1;
  logic [0:0]  ct_data1, pt_data1;
  logic        start64, busy64, ks_ready64, ct_valid64, ct_ready64, pt_valid64, pt_ready64;
  logic [63:0] ct_data64, pt_data64;

  int checks = 0;
  int errors = 0;

  logic [1:288] m;
  logic [127:0] ref_zero;

  always #5 clk = ~clk;

  trivium_stream_decrypt #(.WORD_BITS(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .key(key), .iv(iv),
    .busy(busy8), .ks_ready(ks_ready8), .ct_valid(ct_valid8), .ct_ready(ct_ready8),
    .ct_data(ct_data8), .pt_valid(pt_valid8), .pt_ready(pt_ready8), .pt_data(pt_data8)
  );

  trivium_stream_decrypt #(.WORD_BITS(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .key(key), .iv(iv),
    .busy(busy1), .ks_ready(ks_ready1), .ct_valid(ct_valid1), .ct_ready(ct_ready1),
    .ct_data(ct_data1), .pt_valid(pt_valid1), .pt_ready(pt_ready1), .pt_data(pt_data1)
  );

  trivium_stream_decrypt #(.WORD_BITS(64)) u64 (
    .clk(clk), .rst(rst), .start(start64), .key(key), .iv(iv),
    .busy(busy64), .ks_ready(ks_ready64), .ct_valid(ct_valid64), .ct_ready(ct_ready64),
    .ct_data(ct_data64), .pt_valid(pt_valid64), .pt_ready(pt_ready64), .pt_data(pt_data64)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(output logic z);
    logic t1, t2, t3;
    t1 = m[66] ^ m[93];
    t2 = m[162] ^ m[177];
    t3 = m[243] ^ m[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (m[91] & m[92]) ^ m[171];
    t2 = t2 ^ (m[175] & m[176]) ^ m[264];
    t3 = t3 ^ (m[286] & m[287]) ^ m[69];
    m[1:93]    = {t3, m[1:92]};
    m[94:177]  = {t1, m[94:176]};
    m[178:288] = {t2, m[178:287]};
  endtask

  // Loads key/iv into the model and discards the 1152 warm-up bits.
  task automatic model_load(input logic [79:0] k, input logic [79:0] v);
    logic z;
    m = '0;
    for (int i = 0; i < 80; i++) begin
      m[i + 1]  = k[i];
      m[i + 94] = v[i];
    end
    m[286] = 1'b1;
    m[287] = 1'b1;
    m[288] = 1'b1;
    for (int i = 0; i < 1152; i++) model_step(z);
  endtask

  task automatic model_byte(output logic [7:0] w);
    logic z;
    for (int i = 0; i < 8; i++) begin
      model_step(z);
      w[i] = z;
    end
  endtask

  task automatic count_busy8(output int n);
    n = 0;
    while (busy8 === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    start8 = 1'b1;
    key = 80'h1;
    iv = 80'h2;
    tick();
    tick();
    checks++;
    if ({busy8, ks_ready8, pt_valid8, ct_ready8} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags8: got %b expected 0000", {busy8, ks_ready8, pt_valid8, ct_ready8});
    end
    checks++;
    if (pt_data8 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_pt_data8: got %h expected 00", pt_data8);
    end
    checks++;
    if ({busy1, ks_ready1, pt_valid1, ct_ready1, busy64, ks_ready64, pt_valid64, ct_ready64} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_flags_1_64: got %b expected 00000000",
               {busy1, ks_ready1, pt_valid1, ct_ready1, busy64, ks_ready64, pt_valid64, ct_ready64});
    end
    rst = 1'b1;
    start8 = 1'b0;
    tick();
    checks++;
    if ({busy8, ks_ready8, pt_valid8, ct_ready8} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got %b expected 0000", {busy8, ks_ready8, pt_valid8, ct_ready8});
    end
  endtask

  task automatic test_zero_key;
    int n;
    key = '0;
    iv = '0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    count_busy8(n);
    checks++;
    if (n !== 144) begin
      errors++;
      $display("[TB] FAIL warmup_cycles8: got %0d expected 144", n);
    end
    checks++;
    if ({ks_ready8, ct_ready8} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL run_ready8: got %b expected 11", {ks_ready8, ct_ready8});
    end
    pt_ready8 = 1'b1;
    for (int w = 0; w < 16; w++) begin
      ct_valid8 = 1'b1;
      ct_data8 = 8'h00;
      tick();
      checks++;
      if (pt_valid8 !== 1'b1 || pt_data8 !== ref_zero[w*8 +: 8]) begin
        errors++;
        $display("[TB] FAIL zero_ks8 word %0d: got v=%b %h expected v=1 %h", w, pt_valid8, pt_data8, ref_zero[w*8 +: 8]);
      end
    end
    ct_valid8 = 1'b0;
    tick();
    checks++;
    if (pt_valid8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain8: got pt_valid %b expected 0", pt_valid8);
    end
  endtask

  task automatic test_zero_key_w1;
    int n;
    key = '0;
    iv = '0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    while (busy1 === 1'b1 && n < 3000) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 1152 || ks_ready1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL warmup_cycles1: got %0d ks_ready %b expected 1152 ks_ready 1", n, ks_ready1);
    end
    pt_ready1 = 1'b1;
    for (int w = 0; w < 128; w++) begin
      ct_valid1 = 1'b1;
      ct_data1 = w[0];
      tick();
      checks++;
      if (pt_valid1 !== 1'b1 || pt_data1 !== (ref_zero[w] ^ w[0])) begin
        errors++;
        $display("[TB] FAIL zero_ks1 bit %0d: got v=%b %b expected v=1 %b", w, pt_valid1, pt_data1, ref_zero[w] ^ w[0]);
      end
    end
    ct_valid1 = 1'b0;
    tick();
  endtask

  task automatic test_zero_key_w64;
    int n;
    key = '0;
    iv = '0;
    start64 = 1'b1;
    tick();
    start64 = 1'b0;
    n = 0;
    while (busy64 === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 18 || ks_ready64 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL warmup_cycles64: got %0d ks_ready %b expected 18 ks_ready 1", n, ks_ready64);
    end
    pt_ready64 = 1'b1;
    for (int w = 0; w < 2; w++) begin
      ct_valid64 = 1'b1;
      ct_data64 = '0;
      tick();
      checks++;
      if (pt_valid64 !== 1'b1 || pt_data64 !== ref_zero[w*64 +: 64]) begin
        errors++;
        $display("[TB] FAIL zero_ks64 word %0d: got v=%b %h expected v=1 %h", w, pt_valid64, pt_data64, ref_zero[w*64 +: 64]);
      end
    end
    ct_valid64 = 1'b0;
    tick();
  endtask

  task automatic test_round_trip;
    int n;
    logic [7:0] ks;
    logic [7:0] p;
    int bad;
    key = 80'h0123456789ABCDEF0123;
    iv = 80'hFEDCBA98765432100F0F;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    count_busy8(n);
    checks++;
    if (n !== 144) begin
      errors++;
      $display("[TB] FAIL rt_warmup: got %0d expected 144", n);
    end
    model_load(key, iv);
    pt_ready8 = 1'b1;
    bad = 0;
    for (int b = 0; b < 256; b++) begin
      p = 8'(b);
      model_byte(ks);
      ct_valid8 = 1'b1;
      ct_data8 = p ^ ks;
      tick();
      checks++;
      if (pt_valid8 !== 1'b1 || pt_data8 !== p) begin
        errors++;
        if (bad < 8) $display("[TB] FAIL round_trip byte %0d: got v=%b %h expected v=1 %h", b, pt_valid8, pt_data8, p);
        bad++;
      end
    end
    ct_valid8 = 1'b0;
    tick();
  endtask

  task automatic test_backpressure;
    int n;
    logic [7:0] ks0, ks1, ks2;
    key = 80'h13579BDF02468ACE1122;
    iv = 80'h0F1E2D3C4B5A69788796;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    count_busy8(n);
    model_load(key, iv);
    model_byte(ks0);
    model_byte(ks1);
    model_byte(ks2);
    pt_ready8 = 1'b0;
    ct_valid8 = 1'b1;
    ct_data8 = 8'h11 ^ ks0;
    tick();
    ct_data8 = 8'h22 ^ ks1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (pt_valid8 !== 1'b1 || pt_data8 !== 8'h11 || ct_ready8 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle %0d: got v=%b %h ct_ready=%b expected v=1 11 ct_ready=0", c, pt_valid8, pt_data8, ct_ready8);
      end
    end
    pt_ready8 = 1'b1;
    #1;
    checks++;
    if (ct_ready8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release_ready: got %b expected 1", ct_ready8);
    end
    tick();
    checks++;
    if (pt_valid8 !== 1'b1 || pt_data8 !== 8'h22) begin
      errors++;
      $display("[TB] FAIL bp_word1: got v=%b %h expected v=1 22", pt_valid8, pt_data8);
    end
    ct_data8 = 8'h33 ^ ks2;
    tick();
    checks++;
    if (pt_valid8 !== 1'b1 || pt_data8 !== 8'h33) begin
      errors++;
      $display("[TB] FAIL bp_word2: got v=%b %h expected v=1 33", pt_valid8, pt_data8);
    end
    ct_valid8 = 1'b0;
    tick();
    checks++;
    if (pt_valid8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_drain: got %b expected 0", pt_valid8);
    end
  endtask

  task automatic test_restart;
    int n;
    logic [7:0] ks;
    logic [7:0] p;
    key = 80'hAAAA5555AAAA5555AAAA;
    iv = 80'h5555AAAA5555AAAA5555;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    count_busy8(n);
    pt_ready8 = 1'b0;
    ct_valid8 = 1'b1;
    ct_data8 = 8'h5A;
    tick();
    ct_valid8 = 1'b0;
    checks++;
    if (pt_valid8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_pending: got %b expected 1", pt_valid8);
    end
    key = 80'hDEADBEEFCAFEF00D1234;
    iv = 80'h00000000000000000001;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    checks++;
    if (pt_valid8 !== 1'b0 || busy8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_flush: got v=%b busy=%b expected v=0 busy=1", pt_valid8, busy8);
    end
    for (int c = 0; c < 50; c++) tick();
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_midwarm_busy: got %b expected 1", busy8);
    end
    key = 80'h89ABCDEF0123456789AB;
    iv = 80'h3141592653589793238F;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    count_busy8(n);
    checks++;
    if (n !== 144) begin
      errors++;
      $display("[TB] FAIL restart_warmup: got %0d expected 144", n);
    end
    model_load(key, iv);
    pt_ready8 = 1'b1;
    for (int w = 0; w < 4; w++) begin
      p = 8'(w * 17 + 3);
      model_byte(ks);
      ct_valid8 = 1'b1;
      ct_data8 = p ^ ks;
      tick();
      checks++;
      if (pt_valid8 !== 1'b1 || pt_data8 !== p) begin
        errors++;
        $display("[TB] FAIL restart_data word %0d: got v=%b %h expected v=1 %h", w, pt_valid8, pt_data8, p);
      end
    end
    ct_valid8 = 1'b0;
    tick();
  endtask

  initial begin
    logic z;
    rst = 1'b0;
    key = '0;
    iv = '0;
    start8 = 1'b0;  ct_valid8 = 1'b0;  ct_data8 = '0;  pt_ready8 = 1'b0;
    start1 = 1'b0;  ct_valid1 = 1'b0;  ct_data1 = '0;  pt_ready1 = 1'b0;
    start64 = 1'b0; ct_valid64 = 1'b0; ct_data64 = '0; pt_ready64 = 1'b0;
    model_load(80'h0, 80'h0);
    for (int k = 0; k < 128; k++) begin
      model_step(z);
      ref_zero[k] = z;
    end
    test_reset();
    test_zero_key();
    test_zero_key_w1();
    test_zero_key_w64();
    test_round_trip();
    test_backpressure();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got time limit expected completion");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
